// File: rtl/kv_cache_ctrl_if.sv
// rtl/kv_cache_ctrl_if.sv - append, scan, output-stream and memory-side signals of kv_cache_ctrl
interface kv_cache_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic                  clear;
    logic                  append_valid;
    logic                  append_ready;
    logic [DATA_WIDTH-1:0] append_k;
    logic [DATA_WIDTH-1:0] append_v;

    logic                  scan_start;
    logic                  scan_busy;
    logic                  scan_done;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_k;
    logic [DATA_WIDTH-1:0] out_v;
    logic [AW-1:0]         out_idx;
    logic                  out_last;

    logic [LW-1:0]         seq_len;
    logic                  full;

    logic                  mem_wr_en;
    logic [AW-1:0]         mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_k_wr_data;
    logic [DATA_WIDTH-1:0] mem_v_wr_data;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_k_rd_data;
    logic [DATA_WIDTH-1:0] mem_v_rd_data;

    modport slave (
        input  clear, append_valid, append_k, append_v, scan_start, out_ready,
               mem_k_rd_data, mem_v_rd_data,
        output append_ready, scan_busy, scan_done, out_valid, out_k, out_v, out_idx,
               out_last, seq_len, full, mem_wr_en, mem_wr_addr, mem_k_wr_data,
               mem_v_wr_data, mem_rd_en, mem_rd_addr
    );

    modport master (
        output clear, append_valid, append_k, append_v, scan_start, out_ready,
               mem_k_rd_data, mem_v_rd_data,
        input  append_ready, scan_busy, scan_done, out_valid, out_k, out_v, out_idx,
               out_last, seq_len, full, mem_wr_en, mem_wr_addr, mem_k_wr_data,
               mem_v_wr_data, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/kv_cache_ctrl.sv
// rtl/kv_cache_ctrl.sv - KV cache controller: sequential append, in-order scan over an external 1-cycle memory
module kv_cache_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    kv_cache_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RD, OUT} state_t;

    state_t        r_state;
    logic [LW-1:0] r_seq_len;
    logic [LW-1:0] r_scan_len;
    logic [AW-1:0] r_idx;
    logic          r_scan_done;

    logic w_full;
    logic w_append_ready;
    logic w_append_fire;
    logic w_out_valid;
    logic w_out_last;

    assign w_full         = (r_seq_len == LW'(DEPTH));
    assign w_append_ready = !w_full && !bus.clear;
    assign w_append_fire  = bus.append_valid && w_append_ready;
    assign w_out_valid    = (r_state == OUT);
    assign w_out_last     = w_out_valid && ({1'b0, r_idx} == (r_scan_len - LW'(1)));

    assign bus.append_ready  = w_append_ready;
    assign bus.full          = w_full;
    assign bus.seq_len       = r_seq_len;
    assign bus.scan_busy     = (r_state != IDLE);
    assign bus.scan_done     = r_scan_done;

    // Writes land at the current tail; the address is combinational so the write completes with the fire.
    assign bus.mem_wr_en     = w_append_fire;
    assign bus.mem_wr_addr   = r_seq_len[AW-1:0];
    assign bus.mem_k_wr_data = bus.append_k;
    assign bus.mem_v_wr_data = bus.append_v;

    assign bus.mem_rd_en     = (r_state == RD);
    assign bus.mem_rd_addr   = r_idx;

    // The memory holds its read data while idle, so OUT can stall without re-reading.
    assign bus.out_valid     = w_out_valid;
    assign bus.out_last      = w_out_last;
    assign bus.out_k         = bus.mem_k_rd_data;
    assign bus.out_v         = bus.mem_v_rd_data;
    assign bus.out_idx       = r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_seq_len   <= '0;
            r_scan_len  <= '0;
            r_idx       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (bus.clear) begin
                r_seq_len <= '0;
                r_state   <= IDLE;
            end else begin
                if (w_append_fire) begin
                    r_seq_len <= r_seq_len + LW'(1);
                end
                case (r_state)
                    IDLE: begin
                        if (bus.scan_start) begin
                            // Snapshot excludes an append firing this same cycle.
                            if (r_seq_len != '0) begin
                                r_scan_len <= r_seq_len;
                                r_idx      <= '0;
                                r_state    <= RD;
                            end else begin
                                r_scan_done <= 1'b1;
                            end
                        end
                    end
                    RD: begin
                        r_state <= OUT;
                    end
                    OUT: begin
                        if (bus.out_ready) begin
                            if (w_out_last) begin
                                r_state     <= IDLE;
                                r_scan_done <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + AW'(1);
                                r_state <= RD;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_kv_cache_ctrl.sv
// tb/tb_kv_cache_ctrl.sv - directed scoreboard bench for kv_cache_ctrl with a 1-cycle memory model
module tb_kv_cache_ctrl;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [DW-1:0] k;
        logic [DW-1:0] v;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    exp_t          sb[$];
    logic [DW-1:0] mk_m[DEPTH];
    logic [DW-1:0] mv_m[DEPTH];
    int            m_len;

    logic [DW-1:0] mem_k[DEPTH];
    logic [DW-1:0] mem_v[DEPTH];

    kv_cache_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    kv_cache_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem_k[bus.mem_wr_addr] <= bus.mem_k_wr_data;
            mem_v[bus.mem_wr_addr] <= bus.mem_v_wr_data;
        end
        if (bus.mem_rd_en) begin
            bus.mem_k_rd_data <= mem_k[bus.mem_rd_addr];
            bus.mem_v_rd_data <= mem_v[bus.mem_rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic append_one(input logic [DW-1:0] k, input logic [DW-1:0] v, input bit check_addr);
        @(negedge clk);
        bus.append_valid = 1'b1;
        bus.append_k     = k;
        bus.append_v     = v;
        #1;
        if (check_addr) begin
            chk("append_wr_en", bus.mem_wr_en, 1);
            chk("append_wr_addr", bus.mem_wr_addr, m_len);
        end
        mk_m[m_len] = k;
        mv_m[m_len] = v;
        m_len++;
        @(negedge clk);
        bus.append_valid = 1'b0;
    endtask

    task automatic empty_scan();
        @(negedge clk);
        bus.scan_start = 1'b1;
        #1 chk("empty_busy0", bus.scan_busy, 0);
        @(negedge clk);
        bus.scan_start = 1'b0;
        #1;
        chk("empty_done", bus.scan_done, 1);
        chk("empty_out_valid", bus.out_valid, 0);
        chk("empty_busy1", bus.scan_busy, 0);
        @(negedge clk);
        #1 chk("empty_done_drop", bus.scan_done, 0);
    endtask

    task automatic run_scan(input int stall, input bit app_each);
        exp_t e;
        int   stalled = 0;
        int   cyc = 0;
        bit   done = 1'b0;
        for (int i = 0; i < m_len; i++) begin
            e.k    = mk_m[i];
            e.v    = mv_m[i];
            e.idx  = i[AW-1:0];
            e.last = (i == m_len - 1);
            sb.push_back(e);
        end
        @(negedge clk);
        bus.scan_start = 1'b1;
        #1 chk("scan_busy_pre", bus.scan_busy, 0);
        @(negedge clk);
        bus.scan_start = 1'b0;
        #1 chk("scan_busy_rd", bus.scan_busy, 1);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = (stalled < stall) ? 1'b0 : 1'b1;
            if (app_each && m_len < DEPTH) begin
                bus.append_valid = 1'b1;
                bus.append_k     = DW'($urandom);
                bus.append_v     = DW'($urandom);
            end else begin
                bus.append_valid = 1'b0;
            end
            #1;
            if (bus.append_valid) begin
                chk("scan_append_addr", bus.mem_wr_addr, m_len);
                mk_m[m_len] = bus.append_k;
                mv_m[m_len] = bus.append_v;
                m_len++;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("extra_output", 1, 0);
                    done = 1'b1;
                end else if (!bus.out_ready) begin
                    stalled++;
                    chk("stall_k", bus.out_k, sb[0].k);
                    chk("stall_rd_en", bus.mem_rd_en, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_k", bus.out_k, e.k);
                    chk("out_v", bus.out_v, e.v);
                    chk("out_idx", bus.out_idx, e.idx);
                    chk("out_last", bus.out_last, e.last);
                    if (e.last) done = 1'b1;
                end
            end
        end
        if (!done) chk("scan_timeout", 0, 1);
        @(negedge clk);
        bus.append_valid = 1'b0;
        bus.out_ready    = 1'b0;
        #1;
        chk("scan_done", bus.scan_done, 1);
        chk("scan_end_valid", bus.out_valid, 0);
        chk("scan_end_busy", bus.scan_busy, 0);
        chk("scan_sb_empty", sb.size(), 0);
        @(negedge clk);
        #1 chk("scan_done_drop", bus.scan_done, 0);
    endtask

    task automatic start_and_wait_out();
        int c = 0;
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
        #1;
        while (!bus.out_valid && c < 20) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("wait_out_valid", bus.out_valid, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_len    = 0;
        rst_n             = 1'b0;
        bus.clear         = 1'b0;
        bus.append_valid  = 1'b0;
        bus.append_k      = '0;
        bus.append_v      = '0;
        bus.scan_start    = 1'b0;
        bus.out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_seq_len", bus.seq_len, 0);
        chk("rst_busy", bus.scan_busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_append_ready", bus.append_ready, 1);
        chk("rst_scan_done", bus.scan_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        empty_scan();

        append_one(16'h0011, 16'h0A00, 1'b1);
        append_one(16'h0022, 16'h0A01, 1'b1);
        append_one(16'h0033, 16'h0A02, 1'b1);
        #1;
        chk("idle_wr_en", bus.mem_wr_en, 0);
        chk("seq_len_3", bus.seq_len, 3);
        run_scan(0, 1'b0);

        @(negedge clk);
        bus.clear = 1'b1;
        #1 chk("clear_blocks_append", bus.append_ready, 0);
        @(negedge clk);
        bus.clear = 1'b0;
        #1 chk("clear_seq_len", bus.seq_len, 0);
        m_len = 0;

        append_one(16'h1111, 16'hB000, 1'b1);
        append_one(16'h2222, 16'hB001, 1'b1);
        run_scan(5, 1'b0);
        run_scan(0, 1'b1);
        #1 chk("grow_seq_len", bus.seq_len, m_len);
        run_scan(0, 1'b0);

        while (m_len < DEPTH) append_one(DW'($urandom), DW'($urandom), 1'b1);
        #1;
        chk("full_flag", bus.full, 1);
        chk("full_ready", bus.append_ready, 0);
        @(negedge clk);
        bus.append_valid = 1'b1;
        #1 chk("full_no_write", bus.mem_wr_en, 0);
        @(negedge clk);
        bus.append_valid = 1'b0;
        #1 chk("full_seq_len", bus.seq_len, DEPTH);

        start_and_wait_out();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        #1;
        chk("clr_out_valid", bus.out_valid, 0);
        chk("clr_busy", bus.scan_busy, 0);
        chk("clr_seq_len", bus.seq_len, 0);
        chk("clr_no_done", bus.scan_done, 0);
        m_len = 0;

        append_one(16'h5555, 16'hC000, 1'b0);
        @(negedge clk);
        bus.clear      = 1'b1;
        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.scan_start = 1'b0;
        #1;
        chk("clr_start_busy", bus.scan_busy, 0);
        chk("clr_start_seq", bus.seq_len, 0);
        m_len = 0;

        append_one(16'h7777, 16'hD000, 1'b0);
        append_one(16'h8888, 16'hD001, 1'b0);
        start_and_wait_out();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.scan_busy, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_last", bus.out_last, 0);
        chk("mid_rst_rd_en", bus.mem_rd_en, 0);
        chk("mid_rst_seq", bus.seq_len, 0);
        chk("mid_rst_full", bus.full, 0);
        chk("mid_rst_ready", bus.append_ready, 1);
        m_len = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rst_no_done", bus.scan_done, 0);
        empty_scan();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/kv_cache_ctrl.md
KV_CACHE_CTRL -- requirements
Module: kv_cache_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, K/V element width.
REQ-002 SHALL have parameter DEPTH, default 256, cache entries (power of two, >=2); AW = clog2(DEPTH), LW = AW+1.
REQ-003 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: clear in 1 (sync flush); append_valid in 1; append_ready out 1; append_k in DATA_WIDTH; append_v in DATA_WIDTH.
REQ-005 SHALL have ports: scan_start in 1; scan_busy out 1; scan_done out 1 (one-cycle pulse).
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; out_k out DATA_WIDTH; out_v out DATA_WIDTH; out_idx out AW; out_last out 1.
REQ-007 SHALL have ports: seq_len out LW (valid entries); full out 1.
REQ-008 SHALL have memory-side ports: mem_wr_en out 1; mem_wr_addr out AW; mem_k_wr_data out DATA_WIDTH; mem_v_wr_data out DATA_WIDTH; mem_rd_en out 1; mem_rd_addr out AW; mem_k_rd_data in DATA_WIDTH; mem_v_rd_data in DATA_WIDTH (memory read data is registered, one-cycle latency, held while mem_rd_en low).

Function
REQ-009 full SHALL equal (seq_len == DEPTH); append_ready SHALL equal !full && !clear.
REQ-010 Append fire (append_valid && append_ready) SHALL combinationally drive mem_wr_en=1, mem_wr_addr=seq_len[AW-1:0], mem_k/v_wr_data=append_k/v; mem_wr_en SHALL be 0 otherwise.
REQ-011 seq_len SHALL increment by 1 on the clock edge ending an append fire; never exceeds DEPTH; no wrap-around.
REQ-012 FSM states SHALL be IDLE, RD, OUT; scan_busy SHALL be 1 in RD and OUT.
REQ-013 IDLE: scan_start with seq_len>0 SHALL snapshot scan_len=seq_len (pre-increment value if an append fires same cycle), set idx=0, go RD.
REQ-014 IDLE: scan_start with seq_len==0 SHALL pulse scan_done the next cycle, stay IDLE, emit no outputs.
REQ-015 scan_start SHALL be ignored in RD and OUT.
REQ-016 RD: mem_rd_en=1, mem_rd_addr=idx for exactly one cycle, then go OUT; mem_rd_en SHALL be 0 in all other states.
REQ-017 OUT: out_valid=1; out_k/out_v SHALL pass through mem_k/v_rd_data; out_idx=idx; out_last=(idx==scan_len-1).
REQ-018 OUT with out_ready=0 SHALL hold state; data stays stable (memory holds).
REQ-019 OUT with out_ready=1 and !out_last SHALL increment idx and go RD (throughput one element per two cycles).
REQ-020 OUT with out_ready=1 and out_last SHALL go IDLE and assert scan_done for the following cycle only.
REQ-021 Appends SHALL be accepted concurrently with a scan; they land at addresses >= scan_len and are not included in the active scan.
REQ-022 clear SHALL, at the next edge, set seq_len=0, abort any scan to IDLE (out_valid drops, no scan_done), and block appends that cycle; a scan_start coinciding with clear SHALL be ignored.
REQ-023 out_valid, out_last SHALL be 0 outside OUT; out_k/out_v/out_idx are don't-care when out_valid=0.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, seq_len=0, idx=0, scan_len=0, scan_done=0; hence scan_busy=0, out_valid=0, out_last=0, mem_rd_en=0, full=0, append_ready=1 (clear low).
REQ-025 Reset asserted mid-scan SHALL abort without scan_done; first scan_start after release behaves per REQ-013/014.

Verification
REQ-026 Append 3 entries (k=0x0011,0x0022,0x0033) -> mem_wr_addr 0,1,2; seq_len=3; scan with out_ready=1 -> out_k 0x0011,0x0022,0x0033, out_idx 0..2, out_last on idx 2, scan_done 1 cycle after last handshake.
REQ-027 Fill DEPTH appends -> full=1, append_ready=0; further append_valid causes no mem_wr_en, seq_len stays DEPTH.
REQ-028 scan_start with seq_len=0 -> scan_done pulse next cycle, out_valid never 1, scan_busy stays 0.
REQ-029 seq_len=2, out_ready=0 for 5 cycles in OUT -> out_valid held, out_k stable at entry 0, mem_rd_en 0; then ready -> entry 1 follows.
REQ-030 Scan of 2 with append every cycle -> exactly 2 outputs; seq_len grows; appended data readable by next scan.
REQ-031 clear during OUT -> next cycle IDLE, out_valid=0, seq_len=0, no scan_done; rst_n pulse mid-scan -> all REQ-024 values immediately.
